// File: rtl/atmr_pkg.sv
// Shared encodings for the ATMR sequential voter: operating modes and replica indices.
package atmr_pkg;

  typedef enum logic [1:0] {
    MODE_MAJ     = 2'b00,
    MODE_ORI     = 2'b01,
    MODE_EXCL    = 2'b10,
    MODE_MAJ_ALT = 2'b11
  } mode_e;

  localparam int N_REP   = 3;
  localparam int REP_ORI = 0;
  localparam int REP_MAI = 1;
  localparam int REP_MEN = 2;

endpackage

// File: rtl/atmr_fault_tracker.sv
// Per-replica health tracking: saturating mismatch counter plus a persistence
// streak that raises a sticky fault flag.
module atmr_fault_tracker #(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic             mism,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault
);

  localparam int                STRK_W   = $clog2(PERSIST + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(PERSIST);
  localparam logic [STRK_W-1:0] STRK_SET = STRK_W'(PERSIST - 1);

  logic [STRK_W-1:0] streak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      streak  <= '0;
      fault   <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      streak  <= '0;
      fault   <= 1'b0;
    end else if (valid) begin
      if (mism) begin
        if (err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        if (streak != STRK_MAX)
          streak <= streak + 1'b1;
        // This sample is the PERSIST-th consecutive mismatch (or later).
        if (streak >= STRK_SET)
          fault <= 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/atmr_seq_voter.sv
// Registered majority voter for ori/mai/men replica vectors with per-replica
// fault tracking and a degraded mode that excludes a single faulty replica.
module atmr_seq_voter
  import atmr_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     ori_in,
  input  logic [WIDTH-1:0]     mai_in,
  input  logic [WIDTH-1:0]     men_in,
  input  logic [1:0]           mode,
  input  logic                 clr,
  output logic [WIDTH-1:0]     z,
  output logic                 z_valid,
  output logic [2:0]           mismatch,
  output logic [2:0]           fault,
  output logic [3*CNT_W-1:0]   err_cnt,
  output logic                 multi_err
);

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] o,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] e);
    return (o & a) | (o & e) | (a & e);
  endfunction

  // Two surviving replicas: take agreed bits, hold the previous output elsewhere.
  function automatic logic [WIDTH-1:0] pair_vote(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] agree;
    agree = ~(p ^ q);
    return (p & agree) | (prev & ~agree);
  endfunction

  logic [WIDTH-1:0] maj_p0;
  logic [WIDTH-1:0] z_nxt_p0;
  logic [2:0]       mism_p0;
  logic [WIDTH-1:0] z_p1;
  logic [2:0]       mism_p1;
  logic             multi_p1;
  logic             vld_p1;

  // ---- stage p0: vote and exclusion datapath ----
  assign maj_p0           = maj3(ori_in, mai_in, men_in);
  assign mism_p0[REP_ORI] = |(ori_in ^ maj_p0);
  assign mism_p0[REP_MAI] = |(mai_in ^ maj_p0);
  assign mism_p0[REP_MEN] = |(men_in ^ maj_p0);

  always_comb begin
    z_nxt_p0 = maj_p0;
    case (mode_e'(mode))
      MODE_ORI:  z_nxt_p0 = ori_in;
      MODE_EXCL: begin
        case (fault)
          3'b001:  z_nxt_p0 = pair_vote(mai_in, men_in, z_p1);
          3'b010:  z_nxt_p0 = pair_vote(ori_in, men_in, z_p1);
          3'b100:  z_nxt_p0 = pair_vote(ori_in, mai_in, z_p1);
          default: z_nxt_p0 = maj_p0;
        endcase
      end
      default:   z_nxt_p0 = maj_p0;
    endcase
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      z_p1     <= '0;
      mism_p1  <= '0;
      multi_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        z_p1     <= z_nxt_p0;
        mism_p1  <= mism_p0;
        multi_p1 <= &mism_p0;
      end
    end
  end

  for (genvar i = 0; i < N_REP; i++) begin : g_trk
    atmr_fault_tracker #(
      .CNT_W   (CNT_W),
      .PERSIST (PERSIST)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .valid   (in_valid),
      .mism    (mism_p0[i]),
      .err_cnt (err_cnt[i*CNT_W +: CNT_W]),
      .fault   (fault[i])
    );
  end

  assign z         = z_p1;
  assign z_valid   = vld_p1;
  assign mismatch  = mism_p1;
  assign multi_err = multi_p1;

endmodule
